// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_pkg
//  Description : Shared definitions for the parity serializer: FSM state
//                encodings and the legal word-width range.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Legal range for the DATA_W parameter of parity_serializer
    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DATA   = 2'd1;
    localparam state_t ST_PARITY = 2'd2;

endpackage
`default_nettype wire

// File: rtl/parity_tree.sv
`default_nettype none
// ============================================================================
//  Module      : parity_tree
//  Description : Combinational XOR reduction of a DATA_W-bit word.
//  Ports       : data   - input word
//                parity - XOR of all bits of data
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_tree #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    assign parity = ^data;

endmodule
`default_nettype wire

// File: rtl/parity_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : parity_serializer
//  Description : Accepts a parallel word over a valid/ready handshake and
//                shifts it out LSB first, followed by one parity bit.
//                Back-to-back frames are supported by accepting the next
//                word during the parity-bit cycle.
//  Ports       : clk       - clock, rising edge active
//                rst_n     - asynchronous active-low reset
//                in_valid  - in_data holds a word to send
//                in_ready  - a word can be accepted this cycle
//                in_data   - parallel word to serialise
//                ser_out   - serial bit (data LSB first, then parity)
//                ser_valid - ser_out carries a frame bit
//                ser_last  - high during the parity-bit cycle only
//                par_out   - parity of the frame in flight
//                busy      - FSM is not idle
//  Parameters  : DATA_W (2..32) word width, ODD (0 even / 1 odd parity)
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_serializer
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              par_out,
    output logic              busy
);

    localparam int                 c_cnt_w    = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic               c_odd      = (ODD != 0);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_ser_out;
    logic                r_ser_valid;
    logic                r_ser_last;
    logic                r_par;
    logic                r_busy;

    logic                w_ready;
    logic                w_accept;
    logic                w_tree_par;

    // Ready is decoded from state alone so the upstream sees no
    // combinational path from in_valid.
    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_PARITY);
    assign w_accept = in_valid && w_ready;

    parity_tree #(
        .DATA_W (DATA_W)
    ) u_parity_tree (
        .data   (in_data),
        .parity (w_tree_par)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_par       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_DATA: begin
                    if (r_cnt == c_cnt_last) begin
                        r_state    <= ST_PARITY;
                        r_ser_out  <= r_par;
                        r_ser_last <= 1'b1;
                    end else begin
                        // ser_out always mirrors shift bit 0, so present
                        // the bit that becomes bit 0 after this shift.
                        r_shift   <= r_shift >> 1;
                        r_cnt     <= r_cnt + c_cnt_one;
                        r_ser_out <= r_shift[1];
                    end
                end
                default: begin
                    // IDLE and PARITY share the accept path; accepting in
                    // PARITY chains the next frame with no idle gap.
                    if (w_accept) begin
                        r_state     <= ST_DATA;
                        r_shift     <= in_data;
                        r_cnt       <= '0;
                        r_par       <= w_tree_par ^ c_odd;
                        r_ser_out   <= in_data[0];
                        r_ser_valid <= 1'b1;
                        r_ser_last  <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_ser_last  <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign ser_last  = r_ser_last;
    assign par_out   = r_par;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/parity_serializer.md
PARITY_SERIALIZER -- requirements
Module: parity_serializer

Interface
REQ-001 Parameter DATA_W, default 8, sets the word width in bits; legal range is 2..32.
REQ-002 Parameter ODD, default 0, selects parity mode: 0 gives even parity over data plus parity bit, 1 gives odd.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data holds a word to be sent.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  DATA_W  parallel word to serialise.
REQ-008 ser_out  output  1  serial bit: data LSB first, then the parity bit.
REQ-009 ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-010 ser_last  output  1  high only during the parity-bit cycle.
REQ-011 par_out  output  1  parity of the frame currently in flight, held until the next accept.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM shall have three states: IDLE, DATA and PARITY.
REQ-014 A word shall be accepted on a rising edge where in_valid and in_ready are both high.
REQ-015 in_ready shall be high in IDLE and in PARITY, and low in DATA.
REQ-016 On accept, the block shall latch in_data into a shift register, compute parity as XOR-reduce(in_data) XOR ODD into par_out, clear the bit counter, and enter DATA.
REQ-017 DATA shall last exactly DATA_W cycles. Each cycle drives ser_out equal to shift-register bit 0 and ser_valid=1, then shifts right and increments the counter.
REQ-018 When the counter reaches DATA_W-1, the next state shall be PARITY.
REQ-019 PARITY shall last one cycle with ser_out=par_out, ser_valid=1 and ser_last=1.
REQ-020 The transition out of PARITY depends on a same-cycle accept.
- With an accept, the next state is DATA with the new word: back-to-back frames, no idle gap.
- Without an accept, the next state is IDLE.
REQ-021 Latency shall be one cycle from the accept edge to the first data bit on ser_out. A frame occupies DATA_W+1 consecutive ser_valid cycles.
REQ-022 In IDLE, ser_out, ser_valid and ser_last shall be 0.
REQ-023 in_data changes while the block is not accepting shall have no effect on the frame in flight.
REQ-024 An in_valid deassertion during DATA shall not abort the frame.
REQ-025 The bit counter shall be clog2(DATA_W) bits wide and shall never exceed DATA_W-1.
REQ-026 All outputs shall be driven from registers, except in_ready, which is decoded from state only.

Reset
REQ-027 Asserting rst_n low shall immediately force the FSM to IDLE and all registers to 0, regardless of clock.
REQ-028 After reset, outputs shall be: in_ready=1, ser_out=0, ser_valid=0, ser_last=0, par_out=0, busy=0.
REQ-029 Reset asserted mid-frame shall drop the frame; no partial bits shall appear after release.
REQ-030 After rst_n deasserts, the first accept shall be possible on the first rising edge.

Structure
REQ-031 A shared package parity_pkg shall hold the FSM state encodings (IDLE=2'd0, DATA=2'd1, PARITY=2'd2) and the DATA_W legal-range limits.
REQ-032 One sub-module, parity_tree, shall be used.
- Combinational, parameterised by DATA_W, output ^data.
- Instantiated once at the accept path; the ODD XOR is applied outside it.

Verification
REQ-033 Reset held, then released with in_valid=0 -> in_ready=1, busy=0, ser_valid=0 for 10 cycles.
REQ-034 DATA_W=8, ODD=0, accept 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1 then parity 0; ser_last on cycle 9 only; in_ready low for 8 cycles.
REQ-035 DATA_W=8, ODD=1, accept 8'h00 then, on the PARITY cycle, 8'h07 -> bits 0x8 + parity 1, immediately followed by 1,1,1,0,0,0,0,0 + parity 0; ser_valid continuous for 18 cycles.
REQ-036 DATA_W=4, ODD=0, exhaustive loop over all 16 words (0000..1111) -> each parity bit equals XOR of the four bits; frame length 5 cycles.
REQ-037 rst_n pulsed low asynchronously (mid-cycle) during bit 3 of 8'hFF -> outputs zero within the same cycle; no ser_valid after release until a new accept.
REQ-038 in_valid high continuously with changing in_data during DATA -> only words present on accept edges are serialised; no word is taken while in_ready=0.
